// File: rtl/des_key_scheduler_pkg.sv
// Shared DES key-schedule constants, permutation tables, shift schedule and FSM encoding.
// Tables use DES numbering: entry value b refers to DES bit b (bit 1 = MSB).
package des_key_scheduler_pkg;

   localparam int SUBKEY_W  = 48;
   localparam int ROUNDS    = 16;
   localparam int BANK_KEYS = 8;
   localparam int BANK_W    = SUBKEY_W * BANK_KEYS;
   localparam int HALF_W    = 28;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_DONE = 2'd2
   } des_state_e;

   localparam int PC1_TBL [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   localparam logic [1:0] SHIFT_TBL [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
   };

   // Result is {C, D}; bit 55 is PC-1 output bit 1.
   function automatic logic [2*HALF_W-1:0] pc1_perm(input logic [63:0] key);
      logic [2*HALF_W-1:0] r;
      r = '0;
      for (int j = 0; j < 2*HALF_W; j++) begin
         r[2*HALF_W-1-j] = key[64-PC1_TBL[j]];
      end
      return r;
   endfunction

endpackage

// File: rtl/des_key_scheduler_subkey_gen.sv
// One key-schedule step: rotate C and D left by shift_i (1 or 2), then PC-2 of the rotated pair.
module des_subkey_gen
   import des_key_scheduler_pkg::*;
(
   input  logic [HALF_W-1:0]   c_i,
   input  logic [HALF_W-1:0]   d_i,
   input  logic [1:0]          shift_i,
   output logic [HALF_W-1:0]   c_o,
   output logic [HALF_W-1:0]   d_o,
   output logic [SUBKEY_W-1:0] subkey_o
);

   logic [2*HALF_W-1:0] cd;

   always_comb begin
      if (shift_i == 2'd2) begin
         c_o = {c_i[HALF_W-3:0], c_i[HALF_W-1:HALF_W-2]};
         d_o = {d_i[HALF_W-3:0], d_i[HALF_W-1:HALF_W-2]};
      end else begin
         c_o = {c_i[HALF_W-2:0], c_i[HALF_W-1]};
         d_o = {d_i[HALF_W-2:0], d_i[HALF_W-1]};
      end
      cd = {c_o, d_o};
      subkey_o = '0;
      for (int j = 0; j < SUBKEY_W; j++) begin
         subkey_o[SUBKEY_W-1-j] = cd[2*HALF_W-PC2_TBL[j]];
      end
   end

endmodule

// File: rtl/des_key_scheduler.sv
// Iterative DES key scheduler: one subkey per cycle into two 8-slot banks, encrypt or decrypt order.
// Optional build macro DES_KEY_PARITY_CHK_EN adds the registered parity_err output.
module des_key_scheduler
   import des_key_scheduler_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              key_load,
   input  logic [63:0]       key_in,
   input  logic              decrypt,
   output logic              busy,
   output logic              keys_ready,
   output logic [BANK_W-1:0] round_keys_lo,
   output logic [BANK_W-1:0] round_keys_hi,
   output des_state_e        fsm_state
`ifdef DES_KEY_PARITY_CHK_EN
   ,
   output logic              parity_err
`endif
);

   // Handshake: key_load is a one-cycle request accepted in any state; keys_ready
   // qualifies both banks, which are only stable while it is high.

   des_state_e              state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [HALF_W-1:0]       creg_q, creg_d, dreg_q, dreg_d;
   logic                    dec_q, dec_d;
   logic [2*BANK_W-1:0]     bank_q, bank_d;

   logic [2*HALF_W-1:0]     cd_load;
   logic [HALF_W-1:0]       c_nxt, d_nxt;
   logic [SUBKEY_W-1:0]     subkey;
   logic [3:0]              slot_idx;
   logic [9:0]              slot_base;

   assign cd_load   = pc1_perm(key_in);
   assign slot_idx  = dec_q ? (4'd15 - cnt_q) : cnt_q;
   assign slot_base = 10'(2*BANK_W - 1 - SUBKEY_W * int'(slot_idx));

   des_subkey_gen u_subkey_gen (
      .c_i      (creg_q),
      .d_i      (dreg_q),
      .shift_i  (SHIFT_TBL[cnt_q]),
      .c_o      (c_nxt),
      .d_o      (d_nxt),
      .subkey_o (subkey)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      creg_d  = creg_q;
      dreg_d  = dreg_q;
      dec_d   = dec_q;
      bank_d  = bank_q;
      case (state_q)
         ST_GEN: begin
            creg_d = c_nxt;
            dreg_d = d_nxt;
            bank_d[slot_base -: SUBKEY_W] = subkey;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'(ROUNDS - 1)) begin
               state_d = ST_DONE;
            end
         end
         default: ;
      endcase
      // A new key always restarts generation, aborting any schedule in progress.
      if (key_load) begin
         state_d = ST_GEN;
         cnt_d   = '0;
         dec_d   = decrypt;
         creg_d  = cd_load[2*HALF_W-1:HALF_W];
         dreg_d  = cd_load[HALF_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         creg_q  <= '0;
         dreg_q  <= '0;
         dec_q   <= 1'b0;
         bank_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         creg_q  <= creg_d;
         dreg_q  <= dreg_d;
         dec_q   <= dec_d;
         bank_q  <= bank_d;
      end
   end

   assign busy          = (state_q == ST_GEN);
   assign keys_ready    = (state_q == ST_DONE);
   assign round_keys_lo = bank_q[2*BANK_W-1 -: BANK_W];
   assign round_keys_hi = bank_q[BANK_W-1:0];
   assign fsm_state     = state_q;

`ifdef DES_KEY_PARITY_CHK_EN
   logic parity_q;
   logic key_bad;

   always_comb begin
      key_bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         key_bad |= ~^key_in[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (key_load) begin
         parity_q <= key_bad;
      end
   end

   assign parity_err = parity_q;
`endif

`ifndef SYNTHESIS
   // Sixteen rotations total 28 positions, so C and D return to their PC-1 values.
   logic [HALF_W-1:0] c_load_q, d_load_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         c_load_q <= '0;
         d_load_q <= '0;
      end else if (key_load) begin
         c_load_q <= cd_load[2*HALF_W-1:HALF_W];
         d_load_q <= cd_load[HALF_W-1:0];
      end
   end

   a_rotation_closes: assert property (@(posedge clk) disable iff (rst)
      (state_q == ST_DONE) |-> (creg_q == c_load_q && dreg_q == d_load_q));
`endif

endmodule

// File: tb/tb_des_key_scheduler.sv
// Scoreboard bench for des_key_scheduler: random and directed key loads checked against a
// bit-array DES key-schedule model using cumulative rotation offsets.
module tb_des_key_scheduler;
   import des_key_scheduler_pkg::*;

   localparam int TB_PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int TB_PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int TB_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;

   logic         clk = 1'b0;
   logic         rst, key_load, decrypt;
   logic [63:0]  key_in;
   logic         busy, keys_ready, parity_err;
   logic [383:0] lo, hi;
   des_state_e   fsm_state;

   des_key_scheduler dut (
      .clk           (clk),
      .rst           (rst),
      .key_load      (key_load),
      .key_in        (key_in),
      .decrypt       (decrypt),
      .busy          (busy),
      .keys_ready    (keys_ready),
      .round_keys_lo (lo),
      .round_keys_hi (hi),
      .fsm_state     (fsm_state)
`ifdef DES_KEY_PARITY_CHK_EN
      ,
      .parity_err    (parity_err)
`endif
   );

`ifndef DES_KEY_PARITY_CHK_EN
   assign parity_err = 1'b0;
`endif

   // ---------------- clock / reset / cycle count ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   logic [767:0] exp_q[$];
   int           exp_t_q[$];
   int           pend_until = 0;

   task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [767:0] model_sched(input logic [63:0] key, input logic dec);
      logic        kb [1:64];
      logic        c0 [1:28];
      logic        d0 [1:28];
      logic        cd [1:56];
      logic [47:0] sk;
      logic [767:0] res;
      int          rot, slot;
      for (int b = 1; b <= 64; b++) kb[b] = key[64-b];
      for (int k = 1; k <= 28; k++) begin
         c0[k] = kb[TB_PC1[k-1]];
         d0[k] = kb[TB_PC1[k+27]];
      end
      rot = 0;
      res = '0;
      for (int n = 1; n <= 16; n++) begin
         rot += TB_SH[n-1];
         for (int k = 1; k <= 28; k++) begin
            cd[k]    = c0[((k - 1 + rot) % 28) + 1];
            cd[28+k] = d0[((k - 1 + rot) % 28) + 1];
         end
         sk = '0;
         for (int j = 1; j <= 48; j++) sk = {sk[46:0], cd[TB_PC2[j-1]]};
         slot = dec ? 17 - n : n;
         res[767 - 48*(slot-1) -: 48] = sk;
      end
      return res;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_noise();
      key_in  = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         drive_noise();
         @(posedge clk); #1;
      end
   endtask

   task automatic load_key(input logic [63:0] k, input logic dec);
      if (exp_q.size() > 0 && cyc < pend_until) begin
         void'(exp_q.pop_back());
         void'(exp_t_q.pop_back());
      end
      key_in   = k;
      decrypt  = dec;
      key_load = 1'b1;
      exp_q.push_back(model_sched(k, dec));
      exp_t_q.push_back(cyc + 17);
      pend_until = cyc + 17;
      @(posedge clk); #1;
      key_load = 1'b0;
   endtask

   task automatic clear_expect();
      exp_q.delete();
      exp_t_q.delete();
      pend_until = 0;
   endtask

   task automatic chk_reset_state(input string tag);
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_ready"}, keys_ready, 1'b0);
      chk({tag, "_lo"}, lo, '0);
      chk({tag, "_hi"}, hi, '0);
      chk({tag, "_state"}, fsm_state, ST_IDLE);
      @(posedge clk); #1;
   endtask

   task automatic rst_pulse(input logic with_load);
      rst      = 1'b1;
      key_load = with_load;
      drive_noise();
      @(posedge clk); #1;
      rst      = 1'b0;
      key_load = 1'b0;
      clear_expect();
   endtask

   task automatic run_known(input logic dec, input logic [47:0] exp_lo1, input logic [47:0] exp_hi8);
      int bc;
      load_key(KNOWN_KEY, dec);
      bc = 0;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (busy) bc++;
         drive_noise();
         @(posedge clk); #1;
      end
      chk("busy_cycles", bc, 16);
      @(negedge clk);
      chk("known_ready", keys_ready, 1'b1);
      chk("known_lo_slot1", lo[383:336], exp_lo1);
      chk("known_hi_slot8", hi[47:0], exp_hi8);
      @(posedge clk); #1;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < bound) begin
         idle(1);
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic         prev_ready = 1'b0;
   logic [767:0] prev_keys = '0;
   logic [767:0] mon_e;
   int           mon_t;

   always @(negedge clk) begin
      if (!rst) begin
         if (keys_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ready", 1'b1, 1'b0);
            end else begin
               mon_e = exp_q.pop_front();
               mon_t = exp_t_q.pop_front();
               chk("ready_latency", cyc, mon_t);
               chk("schedule", {lo, hi}, mon_e);
            end
         end else if (keys_ready && prev_ready) begin
            chk("stable_banks", {lo, hi}, prev_keys);
         end
      end
      prev_ready = keys_ready;
      prev_keys  = {lo, hi};
   end

   // ---------------- stimulus ----------------
   initial begin
      rst      = 1'b1;
      key_load = 1'b1;
      key_in   = KNOWN_KEY;
      decrypt  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst      = 1'b0;
      key_load = 1'b0;
      chk_reset_state("reset");

      run_known(1'b0, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
      idle(3);
      run_known(1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);
      idle(2);

      // abort: second load five cycles after the first
      load_key(KNOWN_KEY, 1'b0);
      idle(4);
      load_key(64'h0, 1'b0);
      drain(40);
      @(negedge clk);
      chk("abort_zero_banks", {lo, hi}, '0);
      @(posedge clk); #1;

      // reset wins over a simultaneous key_load mid-generation
      load_key({$urandom, $urandom}, 1'b1);
      idle(7);
      rst_pulse(1'b1);
      chk_reset_state("rst_prio");

`ifdef DES_KEY_PARITY_CHK_EN
      load_key(64'h133457799BBCDFF0, 1'b0);
      @(negedge clk);
      chk("parity_bad", parity_err, 1'b1);
      @(posedge clk); #1;
      drain(40);
      load_key(KNOWN_KEY, 1'b0);
      @(negedge clk);
      chk("parity_good", parity_err, 1'b0);
      @(posedge clk); #1;
      drain(40);
`endif

      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            rst_pulse(1'b0);
            chk_reset_state("rst_mid");
         end else begin
            load_key({$urandom, $urandom}, 1'($urandom_range(0, 1)));
            idle($urandom_range(1, 24));
         end
      end
      drain(40);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001 The block SHALL have no parameters; all sizes SHALL come from package constants.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key_load  input  1  single-cycle pulse that captures key_in and decrypt and starts generation.
REQ-005 key_in  input  64  DES key, bit 63 = DES bit 1, parity bits included.
REQ-006 decrypt  input  1  0 = encryption order (K1..K16), 1 = decryption order (K16..K1).
REQ-007 busy  output  1  high while subkeys are being generated.
REQ-008 keys_ready  output  1  high while both banks hold a complete, valid schedule.
REQ-009 round_keys_lo  output  384  schedule slots 1-8, feeding the first eight-round pass.
REQ-010 round_keys_hi  output  384  schedule slots 9-16, feeding the second eight-round pass.
REQ-011 parity_err  output  1  odd-parity violation on the loaded key (present only with DES_KEY_PARITY_CHK_EN).

Function
REQ-012 In each bank, slot n (1-8) SHALL occupy bits [383-48(n-1) : 336-48(n-1)], so the first slot is in the MSBs.
REQ-013 FSM states SHALL be IDLE, GEN and DONE.
- IDLE -> GEN on key_load.
- GEN -> DONE after the 16th generation cycle.
- DONE -> GEN on key_load.
REQ-014 On key_load, PC-1 of key_in SHALL load the 28-bit C and D registers, a 4-bit round counter SHALL clear, and decrypt SHALL be latched.
REQ-015 Each GEN cycle SHALL produce exactly one subkey:
- rotate C and D left by 1 for rounds 1, 2, 9 and 16, otherwise by 2;
- apply PC-2;
- write slot (i+1) when the latched decrypt = 0, or slot (16-i) when it = 1, where i is the counter value 0-15.
REQ-016 Latency: keys_ready SHALL rise exactly 17 cycles after the key_load cycle; busy SHALL be high for the 16 cycles in between.
REQ-017 keys_ready SHALL stay high with both banks stable until the next key_load or rst.
REQ-018 key_load in GEN or DONE SHALL abort the current schedule and restart from the new key in the next cycle; keys_ready SHALL fall in that cycle.
REQ-019 Round keys SHALL remain visible while regeneration is in progress, but consumers SHALL qualify them with keys_ready.
REQ-020 Input changes on key_in or decrypt without key_load SHALL have no effect.
REQ-021 After 16 rounds the total rotation is 28, so C and D SHALL equal their PC-1 load values at DONE; this SHALL be exposed as a simulation-only assertion.

Reset
REQ-022 rst SHALL force the following, overriding a simultaneous key_load:
- state IDLE, counter 0;
- busy 0, keys_ready 0, parity_err 0;
- both banks all-zero;
- C and D zero.
REQ-023 rst asserted mid-GEN SHALL discard the partial schedule with no residual slot data.

Configuration
REQ-024 With DES_KEY_PARITY_CHK_EN defined:
- parity_err SHALL be registered on the key_load cycle, high if any key byte has even parity;
- it SHALL be held until the next key_load;
- generation SHALL proceed regardless of its value.
REQ-025 Without DES_KEY_PARITY_CHK_EN, the parity_err port and its logic SHALL be absent.

Structure
REQ-026 A shared package SHALL hold:
- the PC-1 and PC-2 tables and the shift schedule;
- the FSM state enum;
- constants SUBKEY_W = 48, ROUNDS = 16, BANK_KEYS = 8.
REQ-027 PC-2 plus the rotation SHALL be one combinational sub-module, des_subkey_gen (inputs C and D plus shift amount; outputs next C, next D and a 48-bit subkey).

Verification
REQ-028 Encrypt order: key_in = 0x133457799BBCDFF1, decrypt = 0, pulse key_load -> keys_ready rises at +17 cycles; lo slot 1 = 0x1B02EFFC7072; hi slot 8 = 0xCB3D8B0E17F5.
REQ-029 Decrypt order: same key with decrypt = 1 -> lo slot 1 = 0xCB3D8B0E17F5; hi slot 8 = 0x1B02EFFC7072; all 16 slots are the exact reverse of REQ-028.
REQ-030 Abort: second key_load at cycle +5 with key 0x0000000000000000 -> keys_ready stays 0 until +22 cycles from the first load; all slots = 0.
REQ-031 Reset priority: rst asserted at +8 together with key_load -> next cycle busy = 0, keys_ready = 0, banks zero, state IDLE.
REQ-032 Parity (macro defined): key 0x133457799BBCDFF0 -> parity_err = 1 and round keys identical to REQ-028; key 0x133457799BBCDFF1 -> parity_err = 0.
